// File: rtl/stf_stream_gen.sv
// L-STF preamble generator: replays the 16-sample short-training period
// NUM_SYM times over valid/ready. Optional macro STF_WINDOW_EN.
module stf_stream_gen #(
    parameter int DATA_W  = 16,
    parameter int NUM_SYM = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        gain_sh,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_i,
    output logic [DATA_W-1:0] out_q,
    output logic              out_last
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [7:0] LAST_SYM = 8'(NUM_SYM - 1);

    state_t            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [7:0]        sym_q, sym_d;
    logic [1:0]        gain_q, gain_d;
    logic              tail_q, tail_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] i_q, i_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic              load;
    logic              hs;
    logic              at_end;
    logic              halve;
    logic signed [15:0] si, sq;

    function automatic logic [15:0] tbl_i(input logic [2:0] k);
        logic [15:0] r;
        unique case (k)
            3'd0: r = 16'hFD0E;
            3'd1: r = 16'h0000;
            3'd2: r = 16'h02F2;
            3'd3: r = 16'h042A;
            3'd4: r = 16'h02F2;
            3'd5: r = 16'h0000;
            3'd6: r = 16'hFD0E;
            3'd7: r = 16'hFBD6;
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] tbl_q(input logic [2:0] k);
        logic [15:0] r;
        unique case (k)
            3'd0: r = 16'hFD0E;
            3'd1: r = 16'hFBD6;
            3'd2: r = 16'hFD0E;
            3'd3: r = 16'h0000;
            3'd4: r = 16'h02F2;
            3'd5: r = 16'h042A;
            3'd6: r = 16'h02F2;
            3'd7: r = 16'h0000;
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    // Top-aligned in a 40-bit field: pads LSBs when wide, truncates when narrow.
    function automatic logic [DATA_W-1:0] fit(input logic [15:0] v);
        logic [39:0] ext;
        ext = {v, 24'd0};
        return ext[39 -: DATA_W];
    endfunction

    assign hs     = valid_q & out_ready;
    assign at_end = (sym_q == LAST_SYM) && (idx_q == 4'd15);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sym_d   = sym_q;
        gain_d  = gain_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        last_d  = last_q;
        i_d     = i_q;
        q_d     = q_q;
        done_d  = 1'b0;
        load    = 1'b0;
        halve   = 1'b0;
        si      = '0;
        sq      = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    gain_d  = gain_sh;
                    idx_d   = 4'd0;
                    sym_d   = 8'd0;
                    tail_d  = 1'b0;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (abort || (hs && last_q)) begin
                    state_d = IDLE;
                    idx_d   = 4'd0;
                    sym_d   = 8'd0;
                    tail_d  = 1'b0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    i_d     = '0;
                    q_d     = '0;
                    done_d  = !abort;
                end else if (hs) begin
                    load = 1'b1;
`ifdef STF_WINDOW_EN
                    if (at_end) begin
                        tail_d = 1'b1;
                        idx_d  = 4'd0;
                    end else
`endif
                    if (idx_q == 4'd15) begin
                        idx_d = 4'd0;
                        sym_d = sym_q + 8'd1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            si = $signed(tbl_i(idx_d[2:0])) >>> gain_d;
            sq = $signed(tbl_q(idx_d[2:0])) >>> gain_d;
`ifdef STF_WINDOW_EN
            halve  = tail_d || (sym_d == 8'd0 && idx_d == 4'd0);
            last_d = tail_d;
`else
            last_d = (sym_d == LAST_SYM) && (idx_d == 4'd15);
`endif
            if (halve) begin
                si = si >>> 1;
                sq = sq >>> 1;
            end
            valid_d = 1'b1;
            i_d     = fit(si);
            q_d     = fit(sq);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            sym_q   <= 8'd0;
            gain_q  <= 2'd0;
            tail_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            i_q     <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sym_q   <= sym_d;
            gain_q  <= gain_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            i_q     <= i_d;
            q_q     <= q_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_i     = i_q;
    assign out_q     = q_q;

endmodule

// File: tb/tb_stf_stream_gen.sv
// Scoreboard bench for stf_stream_gen at 16, 12 and 20 bit widths.
// Follows STF_WINDOW_EN when defined.
module tb_stf_stream_gen;

    localparam int NSYM = 10;
`ifdef STF_WINDOW_EN
    localparam int TOTAL = 16 * NSYM + 1;
    localparam logic [15:0] S0 = 16'hFE87;
    localparam logic [15:0] G0 = 16'hFFA1;
    localparam logic [15:0] LI = 16'hFE87;
    localparam logic [15:0] LQ = 16'hFE87;
`else
    localparam int TOTAL = 16 * NSYM;
    localparam logic [15:0] S0 = 16'hFD0E;
    localparam logic [15:0] G0 = 16'hFF43;
    localparam logic [15:0] LI = 16'hFBD6;
    localparam logic [15:0] LQ = 16'h0000;
`endif

    logic clk = 0, rstn = 0, start = 0, abort = 0, out_ready = 0;
    logic [1:0] gain_sh = 0;
    logic busy, done, out_valid, out_last;
    logic [15:0] out_i, out_q;
    logic b12, d12, v12, l12, b20, d20, v20, l20;
    logic [11:0] i12, q12;
    logic [19:0] i20, q20;

    always #5 clk = ~clk;

    stf_stream_gen #(.DATA_W(16), .NUM_SYM(NSYM)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .gain_sh(gain_sh), .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_i(out_i), .out_q(out_q), .out_last(out_last));

    stf_stream_gen #(.DATA_W(12), .NUM_SYM(NSYM)) dut12 (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .gain_sh(gain_sh), .busy(b12), .done(d12),
        .out_valid(v12), .out_ready(out_ready),
        .out_i(i12), .out_q(q12), .out_last(l12));

    stf_stream_gen #(.DATA_W(20), .NUM_SYM(NSYM)) dut20 (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .gain_sh(gain_sh), .busy(b20), .done(d20),
        .out_valid(v20), .out_ready(out_ready),
        .out_i(i20), .out_q(q20), .out_last(l20));

    typedef struct {
        logic [15:0] i16, q16;
        logic [11:0] i12, q12;
        logic [19:0] i20, q20;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int compared = 0, mismatched = 0;
    int nsamp, nlast;
    logic [15:0] got_i [TOTAL];
    logic [15:0] got_q [TOTAL];
    logic [11:0] got_i12 [TOTAL];
    logic [19:0] got_i20 [TOTAL];

    logic [15:0] ti [8] = '{16'hFD0E, 16'h0000, 16'h02F2, 16'h042A,
                            16'h02F2, 16'h0000, 16'hFD0E, 16'hFBD6};
    logic [15:0] tq [8] = '{16'hFD0E, 16'hFBD6, 16'hFD0E, 16'h0000,
                            16'h02F2, 16'h042A, 16'h02F2, 16'h0000};

    function automatic int mdl(int n, int g, int w, bit isq);
        int k, v;
        k = n % 8;
        v = isq ? int'($signed(tq[k])) : int'($signed(ti[k]));
        v = v >>> g;
`ifdef STF_WINDOW_EN
        if (n == 0 || n == 16 * NSYM) v = v >>> 1;
`endif
        if (w >= 16) return v <<< (w - 16);
        return v >>> (16 - w);
    endfunction

    task automatic push_run(input int g);
        exp_t e;
        for (int n = 0; n < TOTAL; n++) begin
            e.i16  = 16'(mdl(n, g, 16, 0));
            e.q16  = 16'(mdl(n, g, 16, 1));
            e.i12  = 12'(mdl(n, g, 12, 0));
            e.q12  = 12'(mdl(n, g, 12, 1));
            e.i20  = 20'(mdl(n, g, 20, 0));
            e.q20  = 20'(mdl(n, g, 20, 1));
            e.last = (n == TOTAL - 1);
            sb.push_back(e);
        end
    endtask

    task automatic do_start(input logic [1:0] g);
        compared++;
        if ({out_valid, busy} !== 2'b00) begin
            mismatched++;
            $display("FAIL idle_before_start got %b want 00", {out_valid, busy});
        end
        start = 1; gain_sh = g;
        push_run(int'(g));
        @(posedge clk); #1;
        start = 0;
        compared++;
        if ({out_valid, busy, v12, v20} !== 4'b1111) begin
            mismatched++;
            $display("FAIL start_latency got %b want 1111",
                     {out_valid, busy, v12, v20});
        end
    endtask

    task automatic drain(input bit rnd, input int abort_at,
                         input bit chain, input logic [1:0] cg);
        int cyc = 0;
        logic pv = 0, pr = 0, pl = 0;
        logic [15:0] pi = 0, pq = 0;
        exp_t e;
        nsamp = 0; nlast = 0;
        while (sb.size() > 0 && cyc < 4000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            gain_sh = 2'($urandom_range(0, 3));
            if (pv && !pr) begin
                compared++;
                if ({out_valid, out_i, out_q, out_last} !== {1'b1, pi, pq, pl}) begin
                    mismatched++;
                    $display("FAIL stall_hold got %h want %h",
                             {out_valid, out_i, out_q, out_last}, {1'b1, pi, pq, pl});
                end
            end
            if (out_valid && out_ready) begin
                if (nsamp == abort_at) begin
                    abort = 1;
                    @(posedge clk); #1;
                    abort = 0; out_ready = 0;
                    return;
                end
                e = sb.pop_front();
                compared++;
                if ({out_i, out_q, i12, q12, i20, q20, out_last} !==
                    {e.i16, e.q16, e.i12, e.q12, e.i20, e.q20, e.last}) begin
                    mismatched++;
                    $display("FAIL sample[%0d] got %h %h %h %h %h %h %b want %h %h %h %h %h %h %b",
                             nsamp, out_i, out_q, i12, q12, i20, q20, out_last,
                             e.i16, e.q16, e.i12, e.q12, e.i20, e.q20, e.last);
                end
                got_i[nsamp] = out_i; got_q[nsamp] = out_q;
                got_i12[nsamp] = i12; got_i20[nsamp] = i20;
                nlast += int'(out_last);
                nsamp++;
            end
            pv = out_valid; pr = out_ready;
            pi = out_i; pq = out_q; pl = out_last;
            @(posedge clk); #1;
            cyc++;
        end
        if (sb.size() != 0) begin
            compared++; mismatched++;
            $display("FAIL drain_timeout got %0d left want 0", sb.size());
            sb.delete();
        end
        compared++;
        if ({done, out_valid, busy, out_last} !== 4'b1000) begin
            mismatched++;
            $display("FAIL done_pulse got %b want 1000",
                     {done, out_valid, busy, out_last});
        end
        if (chain) begin
            start = 1; gain_sh = cg;
            push_run(int'(cg));
        end
        @(posedge clk); #1;
        start = 0;
        compared++;
        if ({done, out_valid} !== {1'b0, chain}) begin
            mismatched++;
            $display("FAIL done_width got %b want %b", {done, out_valid}, {1'b0, chain});
        end
    endtask

    task automatic check_zero(input string nm);
        compared++;
        if ({busy, done, out_valid, out_last, out_i, out_q,
             b12, d12, v12, l12, i12, q12, b20, d20, v20, l20, i20, q20} !== '0) begin
            mismatched++;
            $display("FAIL %s got %h/%h/%h want all zero", nm,
                     {busy, done, out_valid, out_last, out_i, out_q},
                     {b12, d12, v12, l12, i12, q12}, {b20, d20, v20, l20, i20, q20});
        end
    endtask

    task automatic test_reset;
        rstn = 0;
        #3;
        check_zero("reset_state");
        @(negedge clk); rstn = 1;
        @(posedge clk); #1;
        check_zero("after_reset_release");
    endtask

    task automatic test_basic;
        do_start(2'd0);
        compared++;
        if ({out_i, out_q} !== {S0, S0}) begin
            mismatched++;
            $display("FAIL first_sample got %h want %h", {out_i, out_q}, {S0, S0});
        end
        drain(0, -1, 0, 2'd0);
        compared++;
        if (nsamp !== TOTAL || nlast !== 1) begin
            mismatched++;
            $display("FAIL basic_count got %0d/%0d want %0d/1", nsamp, nlast, TOTAL);
        end
        compared++;
        if ({got_i[3], got_q[3]} !== 32'h042A_0000) begin
            mismatched++;
            $display("FAIL sample3 got %h want 042a0000", {got_i[3], got_q[3]});
        end
        compared++;
        if ({got_i[TOTAL-1], got_q[TOTAL-1]} !== {LI, LQ}) begin
            mismatched++;
            $display("FAIL last_sample got %h want %h",
                     {got_i[TOTAL-1], got_q[TOTAL-1]}, {LI, LQ});
        end
        compared++;
        if ({got_i12[3], got_i20[3]} !== {12'h042, 20'h042A0}) begin
            mismatched++;
            $display("FAIL width_sample3 got %h %h want 042 042a0",
                     got_i12[3], got_i20[3]);
        end
    endtask

    task automatic test_backpressure;
        do_start(2'd0);
        drain(1, -1, 0, 2'd0);
        compared++;
        if (nsamp !== TOTAL || nlast !== 1) begin
            mismatched++;
            $display("FAIL bp_count got %0d/%0d want %0d/1", nsamp, nlast, TOTAL);
        end
    endtask

    task automatic test_gain;
        do_start(2'd2);
        compared++;
        if ({out_i, out_q} !== {G0, G0}) begin
            mismatched++;
            $display("FAIL gain_sample0 got %h want %h", {out_i, out_q}, {G0, G0});
        end
        drain(1, -1, 0, 2'd0);
        compared++;
        if ({got_i[3], got_q[3]} !== 32'h010A_0000) begin
            mismatched++;
            $display("FAIL gain_sample3 got %h want 010a0000", {got_i[3], got_q[3]});
        end
    endtask

    task automatic test_abort;
        logic seen;
        do_start(2'd0);
        drain(0, 37, 0, 2'd0);
        compared++;
        if ({out_valid, busy, out_last, done} !== 4'b0000) begin
            mismatched++;
            $display("FAIL abort_exit got %b want 0000",
                     {out_valid, busy, out_last, done});
        end
        compared++;
        if (nsamp !== 37) begin
            mismatched++;
            $display("FAIL abort_count got %0d want 37", nsamp);
        end
        sb.delete();
        seen = 0;
        repeat (6) begin
            seen |= done;
            @(posedge clk); #1;
        end
        compared++;
        if (seen !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_no_done got %b want 0", seen);
        end
        do_start(2'd1);
        drain(0, -1, 0, 2'd0);
        compared++;
        if (nsamp !== TOTAL) begin
            mismatched++;
            $display("FAIL restart_count got %0d want %0d", nsamp, TOTAL);
        end
    endtask

    task automatic test_back_to_back;
        do_start(2'd3);
        drain(0, -1, 1, 2'd0);
        drain(1, -1, 0, 2'd0);
        compared++;
        if (nsamp !== TOTAL || nlast !== 1) begin
            mismatched++;
            $display("FAIL b2b_count got %0d/%0d want %0d/1", nsamp, nlast, TOTAL);
        end
    endtask

    task automatic test_reset_midrun;
        logic seen;
        do_start(2'd0);
        out_ready = 1;
        repeat (20) begin
            @(posedge clk); #1;
        end
        rstn = 0;
        #1;
        check_zero("midrun_reset");
        sb.delete();
        @(negedge clk); rstn = 1;
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            seen |= done | out_valid;
        end
        compared++;
        if (seen !== 1'b0) begin
            mismatched++;
            $display("FAIL midrun_no_done got %b want 0", seen);
        end
        do_start(2'd0);
        drain(0, -1, 0, 2'd0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gain();
        test_abort();
        test_back_to_back();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
